id_ex_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded operands and control from the decode stage and resolves EX/MEM and MEM/WB data forwarding. It drives the ALU's two operands, shift amount and ALUOp. It also detects load-use hazards and inserts bubbles, with a ready/valid handshake toward decode and a ready input from downstream.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/fwd_mux.sv | 36 +++
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: datapath constants, ALUOp encodings and the control bundle.
package mips_pkg;

   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int OPW = 5;

   typedef enum logic [OPW-1:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_NOR  = 5'd5,
      ALU_SLT  = 5'd6,
      ALU_SLTU = 5'd7,
      ALU_SLL  = 5'd8,
      ALU_SRL  = 5'd9,
      ALU_SRA  = 5'd10,
      ALU_LUI  = 5'd11
   } aluop_e;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic branch;
   } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, register 0 is never forwarded.
module fwd_mux #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          i_en,
   input  logic [RW-1:0] i_idx,
   input  logic [DW-1:0] i_stored,
   input  logic          i_s1_we,
   input  logic [RW-1:0] i_s1_rd,
   input  logic [DW-1:0] i_s1_data,
   input  logic          i_s2_we,
   input  logic [RW-1:0] i_s2_rd,
   input  logic [DW-1:0] i_s2_data,
   output logic [DW-1:0] o_data
);

   logic w_s1_hit;
   logic w_s2_hit;

   assign w_s1_hit = i_en & i_s1_we & (i_s1_rd != {RW{1'b0}}) & (i_s1_rd == i_idx);
   assign w_s2_hit = i_en & i_s2_we & (i_s2_rd != {RW{1'b0}}) & (i_s2_rd == i_idx);

   // Priority select of the freshest producer
   always_comb begin
      o_data = i_stored;
      if (w_s1_hit) begin
         o_data = i_s1_data;
      end else if (w_s2_hit) begin
         o_data = i_s2_data;
      end else begin
         o_data = i_stored;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with load-use stall and operand forwarding.
// Build option: FORWARD_EN enables forwarding; without it every pending writer stalls decode.
module id_ex_stage #(
   parameter int DW  = 32,
   parameter int RW  = 5,
   parameter int OPW = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   output logic           id_ready,
   input  logic [DW-1:0]  id_pc,
   input  logic [RW-1:0]  id_rs,
   input  logic [RW-1:0]  id_rt,
   input  logic [RW-1:0]  id_rd,
   input  logic [DW-1:0]  id_rs_data,
   input  logic [DW-1:0]  id_rt_data,
   input  logic [DW-1:0]  id_imm,
   input  logic [4:0]     id_shamt,
   input  logic [OPW-1:0] id_aluop,
   input  logic           id_alusrc,
   input  logic           id_regwrite,
   input  logic           id_memread,
   input  logic           id_memwrite,
   input  logic           id_memtoreg,
   input  logic           id_branch,
   input  logic           flush,
   input  logic           ex_ready,
   input  logic           exmem_regwrite,
   input  logic [RW-1:0]  exmem_rd,
   input  logic [DW-1:0]  exmem_result,
   input  logic           memwb_regwrite,
   input  logic [RW-1:0]  memwb_rd,
   input  logic [DW-1:0]  memwb_result,
   output logic           ex_valid,
   output logic [DW-1:0]  alu_in1,
   output logic [DW-1:0]  alu_in2,
   output logic [4:0]     alu_shamt,
   output logic [OPW-1:0] alu_op,
   output logic [DW-1:0]  ex_store_data,
   output logic [DW-1:0]  ex_pc,
   output logic [RW-1:0]  ex_rd,
   output logic           ex_regwrite,
   output logic           ex_memread,
   output logic           ex_memwrite,
   output logic           ex_memtoreg,
   output logic           ex_branch
);

   import mips_pkg::*;

`ifdef FORWARD_EN
   localparam logic FWD_ON = 1'b1;
`else
   localparam logic FWD_ON = 1'b0;
`endif

   logic           r_valid;
   ctrl_t          r_ctrl;
   logic [DW-1:0]  r_pc;
   logic [RW-1:0]  r_rs;
   logic [RW-1:0]  r_rt;
   logic [RW-1:0]  r_rd;
   logic [DW-1:0]  r_rs_data;
   logic [DW-1:0]  r_rt_data;
   logic [DW-1:0]  r_imm;
   logic [4:0]     r_shamt;
   logic [OPW-1:0] r_aluop;
   logic           r_alusrc;

   ctrl_t          w_id_ctrl;
   logic [DW-1:0]  w_rs_fwd;
   logic [DW-1:0]  w_rt_fwd;
   logic           w_hz;

   function automatic logic rd_hit(input logic we, input logic [RW-1:0] rd,
                                   input logic [RW-1:0] a, input logic [RW-1:0] b);
      return we & (rd != {RW{1'b0}}) & ((rd == a) | (rd == b));
   endfunction

   assign w_id_ctrl = '{id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch};

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .i_en(FWD_ON), .i_idx(r_rs), .i_stored(r_rs_data),
      .i_s1_we(exmem_regwrite), .i_s1_rd(exmem_rd), .i_s1_data(exmem_result),
      .i_s2_we(memwb_regwrite), .i_s2_rd(memwb_rd), .i_s2_data(memwb_result),
      .o_data(w_rs_fwd)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .i_en(FWD_ON), .i_idx(r_rt), .i_stored(r_rt_data),
      .i_s1_we(exmem_regwrite), .i_s1_rd(exmem_rd), .i_s1_data(exmem_result),
      .i_s2_we(memwb_regwrite), .i_s2_rd(memwb_rd), .i_s2_data(memwb_result),
      .o_data(w_rt_fwd)
   );

   // Stall detection; without forwarding any in-flight writer of a source blocks decode
   always_comb begin
      w_hz = rd_hit(r_valid & r_ctrl.memread, r_rd, id_rs, id_rt);
`ifndef FORWARD_EN
      w_hz = w_hz
           | rd_hit(r_valid & r_ctrl.regwrite, r_rd, id_rs, id_rt)
           | rd_hit(exmem_regwrite, exmem_rd, id_rs, id_rt)
           | rd_hit(memwb_regwrite, memwb_rd, id_rs, id_rt);
`endif
   end

   assign id_ready = ex_ready & ~w_hz;

   // Stage register: reset, flush, bubble, load, or hold with operand refresh
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_ctrl    <= '0;
         r_pc      <= {DW{1'b0}};
         r_rs      <= {RW{1'b0}};
         r_rt      <= {RW{1'b0}};
         r_rd      <= {RW{1'b0}};
         r_rs_data <= {DW{1'b0}};
         r_rt_data <= {DW{1'b0}};
         r_imm     <= {DW{1'b0}};
         r_shamt   <= 5'd0;
         r_aluop   <= {OPW{1'b0}};
         r_alusrc  <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (ex_ready) begin
         if (w_hz) begin
            r_valid <= 1'b0;
         end else begin
            r_valid   <= id_valid;
            r_ctrl    <= w_id_ctrl;
            r_pc      <= id_pc;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_shamt   <= id_shamt;
            r_aluop   <= id_aluop;
            r_alusrc  <= id_alusrc;
         end
      end else begin
         // Capture forwarded values so operands survive their producers retiring
         r_rs_data <= w_rs_fwd;
         r_rt_data <= w_rt_fwd;
      end
   end

   assign ex_valid      = r_valid;
   assign alu_in1       = w_rs_fwd;
   assign alu_in2       = r_alusrc ? r_imm : w_rt_fwd;
   assign ex_store_data = w_rt_fwd;
   assign alu_shamt     = r_shamt;
   assign alu_op        = r_aluop;
   assign ex_pc         = r_pc;
   assign ex_rd         = r_rd;
   assign ex_regwrite   = r_valid & r_ctrl.regwrite;
   assign ex_memread    = r_valid & r_ctrl.memread;
   assign ex_memwrite   = r_valid & r_ctrl.memwrite;
   assign ex_memtoreg   = r_valid & r_ctrl.memtoreg;
   assign ex_branch     = r_valid & r_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow the FORWARD_EN build setting.
module tb_id_ex_stage;

   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int OPW = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           id_valid;
   logic           id_ready;
   logic [DW-1:0]  id_pc;
   logic [RW-1:0]  id_rs, id_rt, id_rd;
   logic [DW-1:0]  id_rs_data, id_rt_data, id_imm;
   logic [4:0]     id_shamt;
   logic [OPW-1:0] id_aluop;
   logic           id_alusrc;
   logic           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
   logic           flush, ex_ready;
   logic           exmem_regwrite, memwb_regwrite;
   logic [RW-1:0]  exmem_rd, memwb_rd;
   logic [DW-1:0]  exmem_result, memwb_result;
   logic           ex_valid;
   logic [DW-1:0]  alu_in1, alu_in2, ex_store_data, ex_pc;
   logic [4:0]     alu_shamt;
   logic [OPW-1:0] alu_op;
   logic [RW-1:0]  ex_rd;
   logic           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;

   int checks_r   = 0;
   int failures_r = 0;

   id_ex_stage #(.DW(DW), .RW(RW), .OPW(OPW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
      .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_branch(id_branch),
      .flush(flush), .ex_ready(ex_ready), .exmem_regwrite(exmem_regwrite),
      .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
      .memwb_rd(memwb_rd), .memwb_result(memwb_result), .ex_valid(ex_valid),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_op(alu_op),
      .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks_r++;
      if (act !== exp) begin
         failures_r++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ctl = {regwrite, memread, memwrite, memtoreg, branch}
   task automatic drive_id(input logic v, input logic [DW-1:0] pc,
                           input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                           input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d, input logic [DW-1:0] imm,
                           input logic [OPW-1:0] op, input logic src, input logic [4:0] ctl);
      id_valid    = v;
      id_pc       = pc;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_rs_data  = rs_d;
      id_rt_data  = rt_d;
      id_imm      = imm;
      id_shamt    = 5'd3;
      id_aluop    = op;
      id_alusrc   = src;
      id_regwrite = ctl[4];
      id_memread  = ctl[3];
      id_memwrite = ctl[2];
      id_memtoreg = ctl[1];
      id_branch   = ctl[0];
   endtask

   task automatic fwd_off();
      exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
      memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      fwd_off();
      drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 5'd4, 1'b1, 5'b11111);
      tick(); tick();
      check_eq("rst_valid", {31'd0, ex_valid}, 32'd0);
      check_eq("rst_ctrl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}, 32'd0);
      check_eq("rst_aluop", {27'd0, alu_op}, 32'd0);
      check_eq("rst_pc", ex_pc, 32'd0);
      check_eq("rst_rd", {27'd0, ex_rd}, 32'd0);
      check_eq("rst_in1", alu_in1, 32'd0);
      check_eq("rst_ready", {31'd0, id_ready}, 32'd1);
      rst = 1'b0;

      // Plain accept
      drive_id(1'b1, 32'h200, 5'd5, 5'd6, 5'd9, 32'hDEAD, 32'hBEEF, 32'h10, 5'd2, 1'b0, 5'b10000);
      tick();
      check_eq("acc_valid", {31'd0, ex_valid}, 32'd1);
      check_eq("acc_in1", alu_in1, 32'hDEAD);
      check_eq("acc_in2", alu_in2, 32'hBEEF);
      check_eq("acc_shamt", {27'd0, alu_shamt}, 32'd3);
      check_eq("acc_op", {27'd0, alu_op}, 32'd2);
      check_eq("acc_pc", ex_pc, 32'h200);
      check_eq("acc_rd", {27'd0, ex_rd}, 32'd9);
      check_eq("acc_regwrite", {31'd0, ex_regwrite}, 32'd1);

      // EX/MEM forward onto registered rs=5
      id_valid = 1'b0;
      exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h1234;
      #1;
`ifdef FORWARD_EN
      check_eq("exmem_fwd", alu_in1, 32'h1234);
`else
      check_eq("exmem_nofwd", alu_in1, 32'hDEAD);
`endif
      check_eq("exmem_rt_untouched", alu_in2, 32'hBEEF);
      fwd_off();

      // Priority and register 0
      drive_id(1'b1, 32'h204, 5'd7, 5'd0, 5'd8, 32'h77, 32'h55, 32'h10, 5'd1, 1'b1, 5'b00000);
      tick();
      exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'hA;
      memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_result = 32'hB;
      #1;
`ifdef FORWARD_EN
      check_eq("prio_both", alu_in1, 32'hA);
`else
      check_eq("prio_both_nofwd", alu_in1, 32'h77);
`endif
      check_eq("prio_imm", alu_in2, 32'h10);
      exmem_regwrite = 1'b0;
      #1;
`ifdef FORWARD_EN
      check_eq("prio_memwb", alu_in1, 32'hB);
`else
      check_eq("prio_memwb_nofwd", alu_in1, 32'h77);
`endif
      exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
      #1;
      check_eq("r0_rs", alu_in1, 32'h77);
      check_eq("r0_store", ex_store_data, 32'h55);
      fwd_off();

      // Load-use: lw r3, then a reader of r3
      drive_id(1'b1, 32'h208, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 32'h4, 5'd0, 1'b1, 5'b11010);
      tick();
      check_eq("lw_memread", {31'd0, ex_memread}, 32'd1);
      check_eq("lw_memtoreg", {31'd0, ex_memtoreg}, 32'd1);
      drive_id(1'b1, 32'h20C, 5'd3, 5'd2, 5'd10, 32'h0, 32'h22, 32'h0, 5'd0, 1'b0, 5'b10000);
      #1;
      check_eq("lu_stall", {31'd0, id_ready}, 32'd0);
      tick();
      check_eq("lu_bubble", {31'd0, ex_valid}, 32'd0);
      check_eq("lu_bubble_mr", {31'd0, ex_memread}, 32'd0);
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h300;
      #1;
`ifdef FORWARD_EN
      check_eq("lu_release", {31'd0, id_ready}, 32'd1);
      tick();
      check_eq("lu_accept", {31'd0, ex_valid}, 32'd1);
      fwd_off();
      memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h3333;
      #1;
`else
      check_eq("nf_stall_exmem", {31'd0, id_ready}, 32'd0);
      tick();
      check_eq("nf_bubble2", {31'd0, ex_valid}, 32'd0);
      fwd_off();
      memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h3333;
      #1;
      check_eq("nf_stall_memwb", {31'd0, id_ready}, 32'd0);
      tick();
      check_eq("nf_bubble3", {31'd0, ex_valid}, 32'd0);
      fwd_off();
      id_rs_data = 32'h3333;
      #1;
      check_eq("nf_release", {31'd0, id_ready}, 32'd1);
      tick();
      check_eq("nf_accept", {31'd0, ex_valid}, 32'd1);
`endif
      check_eq("lu_in1", alu_in1, 32'h3333);
      check_eq("lu_in2", alu_in2, 32'h22);
      check_eq("lu_rd", {27'd0, ex_rd}, 32'd10);
      fwd_off();

      // Hold refresh: MEM/WB supplies r4 only in the first held cycle
      drive_id(1'b1, 32'h210, 5'd4, 5'd0, 5'd12, 32'h11, 32'h0, 32'h0, 5'd3, 1'b0, 5'b00000);
      tick();
      id_valid = 1'b0;
      ex_ready = 1'b0;
      memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h99;
      #1;
`ifdef FORWARD_EN
      check_eq("hold_c1", alu_in1, 32'h99);
`else
      check_eq("hold_c1_nofwd", alu_in1, 32'h11);
`endif
      check_eq("hold_ready", {31'd0, id_ready}, 32'd0);
      tick();
      fwd_off();
      #1;
`ifdef FORWARD_EN
      check_eq("hold_c2", alu_in1, 32'h99);
`else
      check_eq("hold_c2_nofwd", alu_in1, 32'h11);
`endif
      check_eq("hold_valid", {31'd0, ex_valid}, 32'd1);
      tick();
`ifdef FORWARD_EN
      check_eq("hold_c3", alu_in1, 32'h99);
`else
      check_eq("hold_c3_nofwd", alu_in1, 32'h11);
`endif
      check_eq("hold_pc", ex_pc, 32'h210);

      // Flush discards the incoming instruction
      ex_ready = 1'b1;
      flush = 1'b1;
      drive_id(1'b1, 32'h214, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 32'h0, 5'd0, 1'b0, 5'b10100);
      tick();
      flush = 1'b0;
      check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
      check_eq("flush_regwrite", {31'd0, ex_regwrite}, 32'd0);
      check_eq("flush_memwrite", {31'd0, ex_memwrite}, 32'd0);

      // Reset during a hold leaves nothing behind
      drive_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd14, 32'h5, 32'h6, 32'h0, 5'd5, 1'b0, 5'b10000);
      tick();
      check_eq("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
      ex_ready = 1'b0;
      id_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ex_ready = 1'b1;
      #1;
      check_eq("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
      check_eq("mid_rst_pc", ex_pc, 32'd0);
      check_eq("mid_rst_in1", alu_in1, 32'd0);
      check_eq("mid_rst_ready", {31'd0, id_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
      $finish;
   end

endmodule
